// File: rtl/alarm_tone_divgen_pkg.sv
// Shared definitions for the alarm tone divider: cadence FSM state encoding
// and default cadence lengths.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ON     = 2'd1,
    OFF    = 2'd2,
    SNOOZE = 2'd3
  } beep_state_e;

  localparam int CAD_W_DEF      = 24;
  localparam int BEEP_ON_DEF    = 6000000;
  localparam int BEEP_OFF_DEF   = 6000000;
  localparam int SNOOZE_CYC_DEF = 24000000;

endpackage

// File: rtl/alarm_tone_divgen_div_channel.sv
// One divider channel: programmable half-period, square-wave output and a
// one-cycle tick on every toggle. A zero divisor parks the channel at 0.
module div_channel
  import alarm_pkg::*;
#(
  parameter int               CNT_W   = 16,
  parameter logic [CNT_W-1:0] RST_DIV = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] div_half,
  output logic             clk_o,
  output logic             tick_o,
  output logic             clk_nxt_o
);

  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q + CNT_W'(1);
    clk_d    = clk_q;
    tick_d   = 1'b0;
    if (load) begin
      shadow_d = div_half;
      cnt_d    = '0;
      clk_d    = 1'b0;
    end else if (shadow_q == '0) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (cnt_q == shadow_q - CNT_W'(1)) begin
      cnt_d  = '0;
      clk_d  = ~clk_q;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= RST_DIV;
      cnt_q    <= '0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
  end

  assign clk_o     = clk_q;
  assign tick_o    = tick_q;
  assign clk_nxt_o = clk_d;

endmodule

// File: rtl/alarm_tone_divgen.sv
// Multi-channel clock divider with divisor reload and a beep-cadence FSM that
// gates one channel onto tone_o. Define ALARM_SNOOZE_EN to add the snooze state.
module alarm_tone_divgen
  import alarm_pkg::*;
#(
  parameter int                      NUM_CH     = 4,
  parameter int                      CNT_W      = 16,
  parameter logic [NUM_CH*CNT_W-1:0] DEF_DIV    = {16'd1251, 16'd16, 16'd520, 16'd2},
  parameter int                      TONE_CH    = 0,
  parameter int                      CAD_W      = CAD_W_DEF,
  parameter int                      BEEP_ON    = BEEP_ON_DEF,
  parameter int                      BEEP_OFF   = BEEP_OFF_DEF
`ifdef ALARM_SNOOZE_EN
  ,parameter int                     SNOOZE_CYC = SNOOZE_CYC_DEF
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*CNT_W-1:0] div_half_i,
  input  logic                    div_load_i,
  input  logic                    alarm_trig_i,
  output logic [NUM_CH-1:0]       clk_div_o,
  output logic [NUM_CH-1:0]       tick_o,
  output logic                    tone_o,
  output logic                    beep_active_o
`ifdef ALARM_SNOOZE_EN
  ,input  logic                   snooze_i
`endif
);

  // The snooze interval can outgrow the cadence width, so the counter widens to fit it.
`ifdef ALARM_SNOOZE_EN
  localparam int CC_W = ($clog2(SNOOZE_CYC) > CAD_W) ? $clog2(SNOOZE_CYC) : CAD_W;
  localparam logic [CC_W-1:0] SNZ_LAST = CC_W'(SNOOZE_CYC - 1);
`else
  localparam int CC_W = CAD_W;
`endif
  localparam logic [CC_W-1:0]   ON_LAST   = CC_W'(BEEP_ON - 1);
  localparam logic [CC_W-1:0]   OFF_LAST  = CC_W'(BEEP_OFF - 1);
  localparam logic [NUM_CH-1:0] TONE_MASK = NUM_CH'(1) << TONE_CH;

  logic [NUM_CH-1:0] clk_nxt;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    div_channel #(
      .CNT_W  (CNT_W),
      .RST_DIV(DEF_DIV[k*CNT_W +: CNT_W])
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .load     (div_load_i),
      .div_half (div_half_i[k*CNT_W +: CNT_W]),
      .clk_o    (clk_div_o[k]),
      .tick_o   (tick_o[k]),
      .clk_nxt_o(clk_nxt[k])
    );
  end

  beep_state_e     state_q, state_d;
  logic [CC_W-1:0] cc_q, cc_d;
  logic            tone_q, tone_d;
  logic            beep_q, beep_d;

  always_comb begin
    state_d = state_q;
    cc_d    = cc_q + CC_W'(1);
    if (!alarm_trig_i) begin
      state_d = IDLE;
      cc_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ON;
          cc_d    = '0;
        end
        ON: begin
`ifdef ALARM_SNOOZE_EN
          if (snooze_i) begin
            state_d = SNOOZE;
            cc_d    = '0;
          end else
`endif
          if (cc_q == ON_LAST) begin
            state_d = OFF;
            cc_d    = '0;
          end
        end
        OFF: begin
`ifdef ALARM_SNOOZE_EN
          if (snooze_i) begin
            state_d = SNOOZE;
            cc_d    = '0;
          end else
`endif
          if (cc_q == OFF_LAST) begin
            state_d = ON;
            cc_d    = '0;
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (cc_q == SNZ_LAST) begin
            state_d = ON;
            cc_d    = '0;
          end
        end
`endif
        default: begin
          state_d = IDLE;
          cc_d    = '0;
        end
      endcase
    end
    // Gate with the channel's next value so tone_o lines up with clk_div_o.
    tone_d = (state_d == ON) & (|(clk_nxt & TONE_MASK));
    beep_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cc_q    <= '0;
      tone_q  <= 1'b0;
      beep_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cc_q    <= cc_d;
      tone_q  <= tone_d;
      beep_q  <= beep_d;
    end
  end

  assign tone_o        = tone_q;
  assign beep_active_o = beep_q;

endmodule

// File: tb/tb_alarm_tone_divgen.sv
// Self-checking bench for alarm_tone_divgen: cycle-index model of the dividers
// and beep cadence, plus directed literal expectations.
module tb_alarm_tone_divgen;

  localparam int NCH   = 4;
  localparam int CW    = 16;
  localparam int B_ON  = 10;
  localparam int B_OFF = 6;
  localparam int SNZ   = 20;
  localparam int TCH   = 0;
  localparam logic [NCH*CW-1:0] DEF = {16'd1251, 16'd16, 16'd520, 16'd2};

  logic              clk = 1'b0;
  logic              rst;
  logic              load;
  logic              trig;
  logic [NCH*CW-1:0] div_half;
  logic [NCH-1:0]    clk_div;
  logic [NCH-1:0]    tick;
  logic              tone;
  logic              beep;
`ifdef ALARM_SNOOZE_EN
  logic              snooze;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: per-channel divisor and cycles since its counter was cleared;
  // alarm mode 0 idle / 1 cadence (k cycles in) / 2 snooze (s cycles in).
  int m_d[NCH];
  int m_n[NCH];
  int m_mode;
  int m_k;
  int m_s;

  always #5 clk = ~clk;

  alarm_tone_divgen #(
    .NUM_CH    (NCH),
    .CNT_W     (CW),
    .DEF_DIV   (DEF),
    .TONE_CH   (TCH),
    .CAD_W     (24),
    .BEEP_ON   (B_ON),
    .BEEP_OFF  (B_OFF)
`ifdef ALARM_SNOOZE_EN
    ,.SNOOZE_CYC(SNZ)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .div_half_i   (div_half),
    .div_load_i   (load),
    .alarm_trig_i (trig),
    .clk_div_o    (clk_div),
    .tick_o       (tick),
    .tone_o       (tone),
    .beep_active_o(beep)
`ifdef ALARM_SNOOZE_EN
    ,.snooze_i    (snooze)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic exp_clk(input int d, input int n);
    return (d > 0) ? (((n / d) % 2) == 1) : 1'b0;
  endfunction

  function automatic logic exp_tick(input int d, input int n);
    return (d > 0) && (n > 0) && ((n % d) == 0);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_d[c] <= int'(DEF[c*CW +: CW]);
        m_n[c] <= 0;
      end
      m_mode <= 0;
      m_k    <= 0;
      m_s    <= 0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (load) begin
          m_d[c] <= int'(div_half[c*CW +: CW]);
          m_n[c] <= 0;
        end else begin
          m_n[c] <= m_n[c] + 1;
        end
      end
      if (!trig) begin
        m_mode <= 0;
      end else if (m_mode == 0) begin
        m_mode <= 1;
        m_k    <= 0;
      end else if (m_mode == 1) begin
`ifdef ALARM_SNOOZE_EN
        if (snooze) begin
          m_mode <= 2;
          m_s    <= 0;
        end else
`endif
        m_k <= m_k + 1;
      end else begin
        if (m_s == SNZ - 1) begin
          m_mode <= 1;
          m_k    <= 0;
        end else begin
          m_s <= m_s + 1;
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic [NCH-1:0] ec;
    logic [NCH-1:0] et;
    logic           etn;
    logic           eb;
    if (chk_en) begin
      for (int c = 0; c < NCH; c++) begin
        ec[c] = exp_clk(m_d[c], m_n[c]);
        et[c] = exp_tick(m_d[c], m_n[c]);
      end
      etn = (m_mode == 1) && ((m_k % (B_ON + B_OFF)) < B_ON) && ec[TCH];
      eb  = (m_mode != 0);
      check("model_clk_div", 32'(clk_div), 32'(ec));
      check("model_tick", 32'(tick), 32'(et));
      check("model_tone", 32'(tone), 32'(etn));
      check("model_beep", 32'(beep), 32'(eb));
    end
  end

  initial begin
    int cnt0;
    int cnt2;
    int tone_hi;
    int off_hi;
    rst      = 1'b1;
    load     = 1'b0;
    trig     = 1'b0;
    div_half = '0;
`ifdef ALARM_SNOOZE_EN
    snooze   = 1'b0;
`endif
    repeat (3) cyc();
    check("reset_clk_div", 32'(clk_div), 32'd0);
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_tone", 32'(tone), 32'd0);
    check("reset_beep", 32'(beep), 32'd0);
    chk_en = 1'b1;
    rst    = 1'b0;

    // Defaults: ch0 half-period 2, ch2 half-period 16.
    repeat (2) cyc();
    check("dflt_first_toggle", 32'(clk_div), 32'b0001);
    check("dflt_first_tick", 32'(tick), 32'b0001);
    cnt0 = 0;
    cnt2 = 0;
    repeat (32) begin
      cyc();
      cnt0 += int'(tick[0]);
      cnt2 += int'(tick[2]);
    end
    check("dflt_ch0_ticks", 32'(cnt0), 32'd16);
    check("dflt_ch2_ticks", 32'(cnt2), 32'd2);

    div_half = {16'd0, 16'd0, 16'd0, 16'd3};
    load     = 1'b1;
    cyc();
    load = 1'b0;
    check("load_clears_clk", 32'(clk_div), 32'd0);
    check("load_clears_tick", 32'(tick), 32'd0);
    repeat (2) cyc();
    check("load_no_early_toggle", 32'(clk_div), 32'd0);
    cyc();
    check("load_toggle_at_3", 32'(clk_div), 32'b0001);
    check("load_tick_at_3", 32'(tick), 32'b0001);
    repeat (20) cyc();
    check("disabled_ch_low", 32'(clk_div[3:1]), 32'd0);

    // Cadence with D0 = 2.
    div_half = {16'd0, 16'd0, 16'd0, 16'd2};
    load     = 1'b1;
    cyc();
    load = 1'b0;
    trig = 1'b1;
    cyc();
    check("beep_rises", 32'(beep), 32'd1);
    tone_hi = int'(tone);
    off_hi  = 0;
    for (int i = 1; i < B_ON + B_OFF; i++) begin
      cyc();
      tone_hi += int'(tone);
      if (i >= B_ON) off_hi += int'(tone);
    end
    check("tone_highs_period", 32'(tone_hi), 32'd5);
    check("tone_silent_off", 32'(off_hi), 32'd0);

    repeat (3) cyc();
    trig = 1'b0;
    cyc();
    check("drop_tone", 32'(tone), 32'd0);
    check("drop_beep", 32'(beep), 32'd0);
    cyc();
    trig = 1'b1;
    cyc();
    check("reraise_beep", 32'(beep), 32'd1);

    // Reset with a simultaneous load, landing in OFF.
    repeat (12) cyc();
    check("in_off_tone", 32'(tone), 32'd0);
    rst      = 1'b1;
    load     = 1'b1;
    div_half = {4{16'd3}};
    cyc();
    check("rst_load_clk_div", 32'(clk_div), 32'd0);
    check("rst_load_tick", 32'(tick), 32'd0);
    check("rst_load_beep", 32'(beep), 32'd0);
    rst  = 1'b0;
    load = 1'b0;
    trig = 1'b0;
    repeat (2) cyc();
    check("rst_restores_default", 32'(clk_div), 32'b0001);

`ifdef ALARM_SNOOZE_EN
    trig = 1'b1;
    cyc();
    check("snz_beep_on", 32'(beep), 32'd1);
    repeat (3) cyc();
    snooze = 1'b1;
    cyc();
    snooze  = 1'b0;
    tone_hi = 0;
    off_hi  = 0;
    for (int i = 0; i < SNZ; i++) begin
      tone_hi += int'(tone);
      off_hi  += int'(!beep);
      if (i < SNZ - 1) cyc();
    end
    check("snz_tone_muted", 32'(tone_hi), 32'd0);
    check("snz_beep_held", 32'(off_hi), 32'd0);
    cyc();
    off_hi = 0;
    for (int i = 0; i < B_ON; i++) begin
      off_hi += int'(tone != clk_div[0]);
      if (i < B_ON - 1) cyc();
    end
    check("snz_resume_on", 32'(off_hi), 32'd0);
`endif

    cyc();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
